// File: rtl/score_pkg.sv
// Shared types and constants for the HUD score path: event codes, point values
// and the ghost-chain multiplier helper.
package score_pkg;

  typedef enum logic [1:0] {
    EV_DOT    = 2'b00,
    EV_PELLET = 2'b01,
    EV_GHOST  = 2'b10,
    EV_FRUIT  = 2'b11
  } ev_type_e;

  typedef enum logic {
    ST_IDLE,
    ST_CONV
  } state_e;

  localparam int DEF_SCORE_W        = 20;
  localparam int DEF_MAX_SCORE      = 999999;
  localparam int DEF_DOT_PTS        = 10;
  localparam int DEF_PELLET_PTS     = 50;
  localparam int DEF_GHOST_BASE     = 200;
  localparam int DEF_FRUIT_PTS      = 100;
  localparam int DEF_EXTRA_LIFE_PTS = 10000;
  localparam int NUM_DIGITS         = 6;

  localparam logic [1:0] GHOST_MULT_MAX = 2'd3;

  // Ghost value doubles per ghost in a frightened chain, capped at 8x.
  function automatic logic [1:0] ghost_mult_next(input logic [1:0] m);
    return (m == GHOST_MULT_MAX) ? m : m + 2'd1;
  endfunction

endpackage

// File: rtl/score_accumulator_if.sv
// Scoring-event valid/ready handshake between gameplay blocks and the score writer.
interface score_accumulator_if;
  import score_pkg::*;

  logic     i_event_valid;
  ev_type_e i_event_type;
  logic     o_event_ready;

  modport master (
    output i_event_valid,
    output i_event_type,
    input  o_event_ready
  );

  modport slave (
    input  i_event_valid,
    input  i_event_type,
    output o_event_ready
  );

endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per cycle, BIN_W steps per
// conversion, with an abort that drops an in-flight conversion immediately.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);

  logic [SR_W-1:0]  sr_q, sr_d, sr_adj, sr_step;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // BCD digits sit above the binary bits; adjust each digit, then shift once.
  always_comb begin
    sr_adj = sr_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr_q[BIN_W+4*d +: 4] >= 4'd5) begin
        sr_adj[BIN_W+4*d +: 4] = sr_q[BIN_W+4*d +: 4] + 4'd3;
      end
    end
    sr_step = sr_adj << 1;
  end

  // done_o marks the cycle whose closing edge performs the final step, so the
  // parent can capture bcd_o on that same edge.
  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == CNT_W'(BIN_W - 1));
  assign bcd_o  = sr_step[SR_W-1 -: BCD_W];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which is what keeps this combinational block from inferring a latch.
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (abort_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      sr_d   = {{BCD_W{1'b0}}, bin_i};
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      sr_d  = sr_step;
      cnt_d = cnt_q + CNT_W'(1);
      if (done_o) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values
    // regardless of statement order or which block reads them.
    if (!rst_n) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/score_accumulator.sv
// HUD score writer: accepts scoring events, keeps a saturating binary score,
// republishes it as 6 BCD digits and flags the one-per-game extra-life crossing.
module score_accumulator
  import score_pkg::*;
#(
  parameter int SCORE_W        = DEF_SCORE_W,
  parameter int MAX_SCORE      = DEF_MAX_SCORE,
  parameter int DOT_PTS        = DEF_DOT_PTS,
  parameter int PELLET_PTS     = DEF_PELLET_PTS,
  parameter int GHOST_BASE     = DEF_GHOST_BASE,
  parameter int FRUIT_PTS      = DEF_FRUIT_PTS,
  parameter int EXTRA_LIFE_PTS = DEF_EXTRA_LIFE_PTS
) (
  input  logic                    clk_100mhz,
  input  logic                    reset,
  score_accumulator_if.slave      ev,
  input  logic                    i_clear,
  input  logic                    i_ghost_chain_rst,
  output logic [SCORE_W-1:0]      o_score_bin,
  output logic [4*NUM_DIGITS-1:0] o_digits,
  output logic                    o_digits_valid,
  output logic                    o_extra_life
);

  localparam int DIG_W = 4 * NUM_DIGITS;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [DIG_W-1:0]   digits_q, digits_d;
  logic [1:0]         mult_q, mult_d, mult_base;
  logic               flag_q, flag_d;
  logic               dvalid_q, dvalid_d;
  logic               extra_q, extra_d;
  logic               live_q;

  logic [SCORE_W-1:0] pts, new_score;
  logic [SCORE_W:0]   sum;
  logic               crossing, accept;
  logic               cvt_start, cvt_abort, cvt_busy, cvt_done;
  logic [DIG_W-1:0]   cvt_bcd;

  // live_q holds ready low for the reset cycles themselves; ready never looks
  // at i_event_valid.
  assign ev.o_event_ready = live_q && (state_q == ST_IDLE) && !cvt_busy && !i_clear;
  assign accept           = ev.i_event_valid && ev.o_event_ready;

  always_comb begin
    mult_base = i_ghost_chain_rst ? 2'd0 : mult_q;
    case (ev.i_event_type)
      EV_DOT:    pts = SCORE_W'(DOT_PTS);
      EV_PELLET: pts = SCORE_W'(PELLET_PTS);
      EV_GHOST:  pts = SCORE_W'(GHOST_BASE) << mult_base;
      EV_FRUIT:  pts = SCORE_W'(FRUIT_PTS);
      default:   pts = '0;
    endcase
    sum       = {1'b0, score_q} + {1'b0, pts};
    new_score = (sum > (SCORE_W+1)'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : sum[SCORE_W-1:0];
    crossing  = (score_q < SCORE_W'(EXTRA_LIFE_PTS)) &&
                (new_score >= SCORE_W'(EXTRA_LIFE_PTS));
  end

  bin_to_bcd_seq #(
    .BIN_W  (SCORE_W),
    .DIGITS (NUM_DIGITS)
  ) u_bcd (
    .clk     (clk_100mhz),
    .rst_n   (reset),
    .start_i (cvt_start),
    .abort_i (cvt_abort),
    .bin_i   (new_score),
    .busy_o  (cvt_busy),
    .done_o  (cvt_done),
    .bcd_o   (cvt_bcd)
  );

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    digits_d  = digits_q;
    mult_d    = mult_q;
    flag_d    = flag_q;
    dvalid_d  = 1'b0;
    extra_d   = 1'b0;
    cvt_start = 1'b0;
    cvt_abort = 1'b0;

    if (i_ghost_chain_rst) begin
      mult_d = 2'd0;
    end

    // A new game wins over everything, including a conversion in flight.
    if (i_clear) begin
      state_d   = ST_IDLE;
      score_d   = '0;
      digits_d  = '0;
      mult_d    = 2'd0;
      flag_d    = 1'b0;
      dvalid_d  = 1'b1;
      cvt_abort = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            score_d   = new_score;
            cvt_start = 1'b1;
            state_d   = ST_CONV;
            case (ev.i_event_type)
              EV_GHOST:  mult_d = ghost_mult_next(mult_base);
              EV_PELLET: mult_d = 2'd0;
              default:   ;
            endcase
            if (crossing && !flag_q) begin
              extra_d = 1'b1;
              flag_d  = 1'b1;
            end
          end
        end
        ST_CONV: begin
          if (cvt_done) begin
            digits_d = cvt_bcd;
            dvalid_d = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      score_q  <= '0;
      digits_q <= '0;
      mult_q   <= 2'd0;
      flag_q   <= 1'b0;
      dvalid_q <= 1'b0;
      extra_q  <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      digits_q <= digits_d;
      mult_q   <= mult_d;
      flag_q   <= flag_d;
      dvalid_q <= dvalid_d;
      extra_q  <= extra_d;
      live_q   <= 1'b1;
    end
  end

  assign o_score_bin    = score_q;
  assign o_digits       = digits_q;
  assign o_digits_valid = dvalid_q;
  assign o_extra_life   = extra_q;

endmodule

// File: tb/tb_score_accumulator.sv
// Directed bench for score_accumulator: reset, conversion latency, ghost chain,
// extra-life crossing, saturation and clear-during-conversion.
module tb_score_accumulator;
  import score_pkg::*;

  logic        clk_100mhz = 1'b0;
  logic        reset = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_ghost_chain_rst = 1'b0;
  logic [19:0] o_score_bin;
  logic [23:0] o_digits;
  logic        o_digits_valid;
  logic        o_extra_life;

  int n_cmp = 0;
  int n_err = 0;
  int extra_cnt = 0;
  logic        last_extra;
  logic [19:0] last_score;

  score_accumulator_if ev();

  always #5 clk_100mhz = ~clk_100mhz;

  score_accumulator dut (
    .clk_100mhz        (clk_100mhz),
    .reset             (reset),
    .ev                (ev),
    .i_clear           (i_clear),
    .i_ghost_chain_rst (i_ghost_chain_rst),
    .o_score_bin       (o_score_bin),
    .o_digits          (o_digits),
    .o_digits_valid    (o_digits_valid),
    .o_extra_life      (o_extra_life)
  );

  task automatic tick();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one event (optionally with chain reset on the same edge), record the
  // accept-edge score and extra-life bit, then wait for the digits to publish.
  task automatic send(input ev_type_e t, input logic crst);
    int k;
    k = 0;
    while (!ev.o_event_ready && k < 50) begin
      tick();
      k++;
    end
    check("ready_wait", ev.o_event_ready, 1);
    ev.i_event_valid  = 1'b1;
    ev.i_event_type   = t;
    i_ghost_chain_rst = crst;
    tick();
    ev.i_event_valid  = 1'b0;
    i_ghost_chain_rst = 1'b0;
    last_extra = o_extra_life;
    last_score = o_score_bin;
    if (o_extra_life) extra_cnt++;
    k = 0;
    while (!o_digits_valid && k < 30) begin
      tick();
      k++;
    end
    check("conv_done", o_digits_valid, 1);
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    extra_cnt = 0;
  endtask

  initial begin
    int bad;
    ev.i_event_valid = 1'b0;
    ev.i_event_type  = EV_DOT;

    // 1. Reset held low for three edges.
    repeat (3) tick();
    check("rst_score", o_score_bin, 0);
    check("rst_digits", o_digits, 0);
    check("rst_dvalid", o_digits_valid, 0);
    check("rst_extra", o_extra_life, 0);
    check("rst_ready", ev.o_event_ready, 0);
    reset = 1'b1;
    tick();
    check("rst_ready_rel", ev.o_event_ready, 1);

    // 2. Single dot: latency of the conversion and the ready window.
    ev.i_event_valid = 1'b1;
    ev.i_event_type  = EV_DOT;
    tick();
    ev.i_event_valid = 1'b0;
    check("t2_score", o_score_bin, 10);
    check("t2_ready_e", ev.o_event_ready, 0);
    check("t2_dvalid_e", o_digits_valid, 0);
    bad = 0;
    for (int i = 1; i < 20; i++) begin
      tick();
      if (ev.o_event_ready || o_digits_valid) bad++;
    end
    check("t2_busy_window", bad, 0);
    tick();
    check("t2_dvalid", o_digits_valid, 1);
    check("t2_digits", o_digits, 32'h000010);
    check("t2_ready_back", ev.o_event_ready, 1);
    tick();
    check("t2_dvalid_pulse", o_digits_valid, 0);

    // 3. Clear, then pellet and a ghost chain with resets.
    do_clear();
    check("t3_clr_score", o_score_bin, 0);
    check("t3_clr_digits", o_digits, 0);
    check("t3_clr_dvalid", o_digits_valid, 1);
    send(EV_PELLET, 1'b0); check("t3_pellet", last_score, 50);
    send(EV_GHOST, 1'b0);  check("t3_g1", last_score, 250);
    send(EV_GHOST, 1'b0);  check("t3_g2", last_score, 650);
    send(EV_GHOST, 1'b0);  check("t3_g3", last_score, 1450);
    send(EV_GHOST, 1'b0);  check("t3_g4", last_score, 3050);
    send(EV_GHOST, 1'b0);  check("t3_g5_cap", last_score, 4650);
    i_ghost_chain_rst = 1'b1;
    tick();
    i_ghost_chain_rst = 1'b0;
    send(EV_GHOST, 1'b0);  check("t3_after_rst", last_score, 4850);
    check("t3_digits", o_digits, 32'h004850);
    send(EV_GHOST, 1'b1);  check("t3_same_edge", last_score, 5050);
    send(EV_GHOST, 1'b0);  check("t3_after_same", last_score, 5450);

    // 4. Extra-life crossing, once per game, re-armed by clear.
    do_clear();
    for (int i = 0; i < 99; i++) send(EV_FRUIT, 1'b0);
    for (int i = 0; i < 9; i++) send(EV_DOT, 1'b0);
    check("t4_preload", last_score, 9990);
    check("t4_no_early", extra_cnt, 0);
    send(EV_DOT, 1'b0);
    check("t4_cross_score", last_score, 10000);
    check("t4_cross_pulse", last_extra, 1);
    check("t4_pulse_gone", o_extra_life, 0);
    check("t4_digits", o_digits, 32'h010000);
    send(EV_GHOST, 1'b0);
    check("t4_ghost_score", last_score, 10200);
    check("t4_no_second", last_extra, 0);
    do_clear();
    for (int i = 0; i < 100; i++) send(EV_FRUIT, 1'b0);
    check("t4_rerun_score", last_score, 10000);
    check("t4_rerun_pulse", last_extra, 1);
    check("t4_rerun_count", extra_cnt, 1);

    // 5. Saturation at 999999.
    do_clear();
    for (int i = 0; i < 627; i++) send(EV_GHOST, 1'b0);
    send(EV_FRUIT, 1'b0);
    send(EV_PELLET, 1'b0);
    check("t5_preload", last_score, 999950);
    send(EV_FRUIT, 1'b0);
    check("t5_clamp", last_score, 999999);
    check("t5_digits", o_digits, 32'h999999);
    send(EV_DOT, 1'b0);
    check("t5_stay", last_score, 999999);
    check("t5_digits_again", o_digits, 32'h999999);

    // 6. Clear mid-conversion with valid held high.
    do_clear();
    ev.i_event_valid = 1'b1;
    ev.i_event_type  = EV_DOT;
    tick();
    check("t6_accept", o_score_bin, 10);
    repeat (6) tick();
    check("t6_hold", o_score_bin, 10);
    i_clear = 1'b1;
    tick();
    check("t6_clr_score", o_score_bin, 0);
    check("t6_clr_digits", o_digits, 0);
    check("t6_clr_dvalid", o_digits_valid, 1);
    check("t6_clr_ready", ev.o_event_ready, 0);
    tick();
    check("t6_no_accept", o_score_bin, 0);
    i_clear = 1'b0;
    #1;
    check("t6_ready_back", ev.o_event_ready, 1);
    tick();
    check("t6_resume", o_score_bin, 10);
    ev.i_event_valid = 1'b0;
    bad = 0;
    while (!o_digits_valid && bad < 30) begin
      tick();
      bad++;
    end
    check("t6_done", o_digits_valid, 1);
    check("t6_digits", o_digits, 32'h000010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
